// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 UART receiver that turns the host serial line into LED
// command bytes. It presents a good byte on Cmd with a one-cycle NewCmd strobe
// and reports a bad stop bit on FrameError. A byte with a bad stop bit is
// never presented on Cmd.
//
// Handshake: NewCmd and FrameError are valid-only strobes with no ready.
// Each is high for exactly one Clock cycle, and the two are never high
// together or in back-to-back cycles. Cmd is valid in the NewCmd cycle and
// holds its value until the next good byte, so the consumer may also read
// Cmd later.
module uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Rx,
  output logic [7:0] Cmd,
  output logic       NewCmd,
  output logic       FrameError,
  output logic       Busy,
  output logic [2:0] StateDbg
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic             rx_meta, rx_s;
  logic [CNT_W-1:0] timer;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             half_hit, full_hit;

  assign half_hit = (timer == HALF_LAST);
  assign full_hit = (timer == FULL_LAST);

  // Two-flop synchroniser. Both flops preset to the idle line level so that
  // reset release cannot look like a start edge.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= Rx;
      rx_s    <= rx_meta;
    end
  end

  // State register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. Every sample point is a terminal count of the bit timer.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (!rx_s) state_nxt = S_START;
      S_START:     if (half_hit) state_nxt = rx_s ? S_IDLE : S_DATA;
      S_DATA:      if (full_hit && (bit_idx == 3'd7)) state_nxt = S_STOP;
      // IDLE is re-entered at mid-stop so the next start edge is not missed.
      S_STOP:      if (full_hit) state_nxt = rx_s ? S_IDLE : S_WAIT_IDLE;
      // A held-low line (break) must go high before a new start is accepted.
      S_WAIT_IDLE: if (rx_s) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Output logic. These outputs depend only on the state register.
  always_comb begin
    Busy     = (state != S_IDLE);
    StateDbg = state;
  end

  // Datapath: bit timer, bit index, shift register, command register and strobes.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      timer      <= '0;
      bit_idx    <= 3'd0;
      shift_reg  <= 8'h00;
      Cmd        <= 8'h00;
      NewCmd     <= 1'b0;
      FrameError <= 1'b0;
    end else begin
      NewCmd     <= 1'b0;
      FrameError <= 1'b0;
      case (state)
        S_START: begin
          if (half_hit) begin
            timer   <= '0;
            bit_idx <= 3'd0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DATA: begin
          if (full_hit) begin
            timer              <= '0;
            shift_reg[bit_idx] <= rx_s;
            bit_idx            <= bit_idx + 3'd1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_STOP: begin
          if (full_hit) begin
            timer <= '0;
            if (rx_s) begin
              Cmd    <= shift_reg;
              NewCmd <= 1'b1;
            end else begin
              FrameError <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: timer <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed testbench for uart_cmd_rx, with the bit period set to 16 clocks.
module tb_uart_cmd_rx;

  localparam int CPB = 16;
  localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       Rx    = 1'b1;
  logic [7:0] Cmd;
  logic       NewCmd, FrameError, Busy;
  logic [2:0] StateDbg;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;
  int fall_cyc = 0;
  int last_lat = -1;
  int nc_cnt   = 0;
  int fe_cnt   = 0;
  int viol_cnt = 0;
  logic prev_pulse = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  uart_cmd_rx #(.CLKS_PER_BIT(CPB)) dut (
    .Clock(Clock), .Reset(Reset), .Rx(Rx), .Cmd(Cmd), .NewCmd(NewCmd),
    .FrameError(FrameError), .Busy(Busy), .StateDbg(StateDbg)
  );

  // Clock and cycle counter.
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  // Monitor: records strobes on the falling edge, away from the active edge.
  always @(negedge Clock) begin
    if (NewCmd) begin
      nc_cnt++;
      got_q.push_back(Cmd);
      last_lat = cyc - fall_cyc;
    end
    if (FrameError) fe_cnt++;
    if (NewCmd && FrameError) viol_cnt++;
    if ((NewCmd || FrameError) && prev_pulse) viol_cnt++;
    prev_pulse = NewCmd || FrameError;
  end

  // Driver tasks. Each is entered and left 1 ns after a rising edge.
  task automatic idle(input int n);
    Rx = 1'b1;
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    Rx = v;
    repeat (CPB) @(posedge Clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    fall_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_v);
  endtask

  task automatic test_reset();
    repeat (4) @(posedge Clock);
    #1;
    chk_cnt++; if (Cmd !== 8'h00) $display("FAIL reset_cmd got=%h exp=00", Cmd); else pass_cnt++;
    chk_cnt++; if (NewCmd !== 1'b0) $display("FAIL reset_newcmd got=%b exp=0", NewCmd); else pass_cnt++;
    chk_cnt++; if (FrameError !== 1'b0) $display("FAIL reset_fe got=%b exp=0", FrameError); else pass_cnt++;
    chk_cnt++; if (Busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", Busy); else pass_cnt++;
    Reset = 1'b1;
    idle(2 * CPB);
    chk_cnt++; if (StateDbg !== 3'd0) $display("FAIL reset_release_state got=%0d exp=0", StateDbg); else pass_cnt++;
    chk_cnt++; if (nc_cnt + fe_cnt !== 0) $display("FAIL reset_release_pulses got=%0d exp=0", nc_cnt + fe_cnt); else pass_cnt++;
  endtask

  task automatic test_single();
    logic [7:0] g;
    send_byte(8'h52, 1'b1);
    idle(CPB);
    chk_cnt++; if (nc_cnt !== 1) $display("FAIL single_count got=%0d exp=1", nc_cnt); else pass_cnt++;
    chk_cnt++; if (Cmd !== 8'h52) $display("FAIL single_cmd got=%h exp=52", Cmd); else pass_cnt++;
    g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
    chk_cnt++; if (g !== 8'h52) $display("FAIL single_strobe_cmd got=%h exp=52", g); else pass_cnt++;
    chk_cnt++; if (last_lat !== LAT) $display("FAIL single_latency got=%0d exp=%0d", last_lat, LAT); else pass_cnt++;
    chk_cnt++; if (fe_cnt !== 0) $display("FAIL single_fe got=%0d exp=0", fe_cnt); else pass_cnt++;
    chk_cnt++; if (Busy !== 1'b0) $display("FAIL single_busy got=%b exp=0", Busy); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] g;
    exp_q.push_back(8'h47);
    exp_q.push_back(8'h42);
    send_byte(8'h47, 1'b1);
    send_byte(8'h42, 1'b1);
    idle(CPB);
    chk_cnt++; if (nc_cnt !== 3) $display("FAIL b2b_count got=%0d exp=3", nc_cnt); else pass_cnt++;
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      chk_cnt++; if (g !== e) $display("FAIL b2b_cmd got=%h exp=%h", g, e); else pass_cnt++;
    end
    chk_cnt++; if (Cmd !== 8'h42) $display("FAIL b2b_hold got=%h exp=42", Cmd); else pass_cnt++;
    chk_cnt++; if (fe_cnt !== 0) $display("FAIL b2b_fe got=%0d exp=0", fe_cnt); else pass_cnt++;
  endtask

  task automatic test_glitch();
    Rx = 1'b0;
    repeat (5) @(posedge Clock);
    #1;
    idle(3 * CPB);
    chk_cnt++; if (nc_cnt !== 3) $display("FAIL glitch_newcmd got=%0d exp=3", nc_cnt); else pass_cnt++;
    chk_cnt++; if (fe_cnt !== 0) $display("FAIL glitch_fe got=%0d exp=0", fe_cnt); else pass_cnt++;
    chk_cnt++; if (Cmd !== 8'h42) $display("FAIL glitch_cmd got=%h exp=42", Cmd); else pass_cnt++;
    chk_cnt++; if (Busy !== 1'b0) $display("FAIL glitch_busy got=%b exp=0", Busy); else pass_cnt++;
  endtask

  task automatic test_frame_error();
    send_byte(8'h55, 1'b0);
    Rx = 1'b0;
    repeat (40) @(posedge Clock);
    #1;
    chk_cnt++; if (fe_cnt !== 1) $display("FAIL ferr_count got=%0d exp=1", fe_cnt); else pass_cnt++;
    chk_cnt++; if (nc_cnt !== 3) $display("FAIL ferr_newcmd got=%0d exp=3", nc_cnt); else pass_cnt++;
    chk_cnt++; if (Cmd !== 8'h42) $display("FAIL ferr_cmd got=%h exp=42", Cmd); else pass_cnt++;
    chk_cnt++; if (Busy !== 1'b1) $display("FAIL ferr_busy_low_line got=%b exp=1", Busy); else pass_cnt++;
    chk_cnt++; if (StateDbg !== 3'd4) $display("FAIL ferr_state got=%0d exp=4", StateDbg); else pass_cnt++;
    idle(5);
    chk_cnt++; if (Busy !== 1'b0) $display("FAIL ferr_busy_release got=%b exp=0", Busy); else pass_cnt++;
    idle(3 * CPB);
    chk_cnt++; if (fe_cnt !== 1 || nc_cnt !== 3) $display("FAIL ferr_after got=%0d/%0d exp=1/3", fe_cnt, nc_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] g;
    logic [7:0] a5;
    a5 = 8'hA5;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(a5[i]);
    Rx = a5[4];
    repeat (8) @(posedge Clock);
    #3;
    Reset = 1'b0;
    #1;
    chk_cnt++; if (Cmd !== 8'h00) $display("FAIL midrst_cmd got=%h exp=00", Cmd); else pass_cnt++;
    chk_cnt++; if (Busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", Busy); else pass_cnt++;
    chk_cnt++; if (NewCmd !== 1'b0 || FrameError !== 1'b0) $display("FAIL midrst_strobes got=%b%b exp=00", NewCmd, FrameError); else pass_cnt++;
    Rx = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b1;
    idle(2 * CPB);
    send_byte(8'h3C, 1'b1);
    idle(CPB);
    chk_cnt++; if (nc_cnt !== 4) $display("FAIL midrst_count got=%0d exp=4", nc_cnt); else pass_cnt++;
    g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
    chk_cnt++; if (g !== 8'h3C) $display("FAIL midrst_cmd_after got=%h exp=3c", g); else pass_cnt++;
    chk_cnt++; if (fe_cnt !== 1) $display("FAIL midrst_fe got=%0d exp=1", fe_cnt); else pass_cnt++;
  endtask

  task automatic test_all_bytes();
    int base;
    logic [7:0] g;
    logic [7:0] e;
    base = nc_cnt;
    got_q.delete();
    for (int b = 0; b < 256; b++) begin
      exp_q.push_back(8'(b));
      send_byte(8'(b), 1'b1);
    end
    idle(CPB);
    chk_cnt++; if (nc_cnt - base !== 256) $display("FAIL all_count got=%0d exp=256", nc_cnt - base); else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      chk_cnt++; if (g !== e) $display("FAIL all_cmd got=%h exp=%h", g, e); else pass_cnt++;
    end
    chk_cnt++; if (fe_cnt !== 1) $display("FAIL all_fe got=%0d exp=1", fe_cnt); else pass_cnt++;
    chk_cnt++; if (viol_cnt !== 0) $display("FAIL strobe_overlap got=%0d exp=0", viol_cnt); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_mid_frame();
    test_all_bytes();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
